// File: rtl/rgbw_pkg.sv
// Shared constants and types for the RGBW command sequencer.
package rgbw_pkg;

  // Register map: six live channel registers, two reserved slots.
  localparam int REG_COUNT = 8;
  localparam int CH_COUNT  = 6;
  localparam int ADDR_W    = $clog2(REG_COUNT);

  localparam logic [ADDR_W-1:0] IDX_RED       = 3'd0;
  localparam logic [ADDR_W-1:0] IDX_GREEN     = 3'd1;
  localparam logic [ADDR_W-1:0] IDX_BLUE      = 3'd2;
  localparam logic [ADDR_W-1:0] IDX_WHITE     = 3'd3;
  localparam logic [ADDR_W-1:0] IDX_INTENSITY = 3'd4;
  localparam logic [ADDR_W-1:0] IDX_MODE      = 3'd5;

  // Header opcodes, carried in the upper nibble of the first byte.
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_BURST = 4'h2;
  localparam logic [3:0] OP_LATCH = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_BURST   = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // True when the address maps onto a live channel register.
  function automatic logic is_channel(input logic [ADDR_W-1:0] addr);
    return (addr < 3'd6);
  endfunction

endpackage

// File: rtl/rgbw_cmd_ctrl_if.sv
// Byte stream from the SPI receiver, framed by the active-low chip select.
interface rgbw_cmd_ctrl_if;
  logic       cs;
  logic       rx_rdy;
  logic [7:0] rx_data;

  modport master (output cs, output rx_rdy, output rx_data);
  modport slave  (input  cs, input  rx_rdy, input  rx_data);
endinterface

// File: rtl/rgbw_reg_bank.sv
// Shadow/active register bank with write, clear, atomic copy and dirty tracking.
module rgbw_reg_bank
  import rgbw_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          clr,
  input  logic                          copy,
  output logic [CH_COUNT-1:0][7:0]      active,
  output logic                          dirty
);

  logic [CH_COUNT-1:0][7:0] shadow_q, shadow_d;
  logic [CH_COUNT-1:0][7:0] active_q, active_d;
  logic                     dirty_q,  dirty_d;

  // Next-state of shadow, active and dirty; reserved-slot writes fall through untouched.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    if (clr) begin
      shadow_d = '0;
      dirty_d  = 1'b1;
    end else if (wr_en && is_channel(wr_addr)) begin
      shadow_d[wr_addr] = wr_data;
      dirty_d           = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end
    if (copy) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end else begin
      active_d = active_q;
    end
  end

  // Bank registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
    end
  end

  assign active = active_q;
  assign dirty  = dirty_q;

endmodule

// File: rtl/rgbw_cmd_ctrl.sv
// Frame decoder: turns the SPI byte stream into shadow writes and latches to the PWM bank.
module rgbw_cmd_ctrl
  import rgbw_pkg::*;
#(
  parameter bit AUTO_LATCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  rgbw_cmd_ctrl_if.slave        rx,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic [7:0]            white,
  output logic [7:0]            intensity,
  output logic [7:0]            mode,
  output logic                  update,
  output logic                  frame_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                update_q, update_d;
  logic                frame_err_q, frame_err_d;

  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic                clr_s;
  logic                copy_s;
  logic                dirty_s;
  logic                cs_rise_s;
  logic [3:0]          opcode_s;
  logic [3:0]          arg_s;
  logic [CH_COUNT-1:0][7:0] active_s;

  assign opcode_s  = rx.rx_data[7:4];
  assign arg_s     = rx.rx_data[3:0];
  assign cs_rise_s = rx.cs & ~cs_q;

  // Next-state, bank controls and pulse outputs; a high chip select overrides any byte.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cs_d        = rx.cs;
    update_d    = 1'b0;
    frame_err_d = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = addr_q;
    clr_s       = 1'b0;
    copy_s      = 1'b0;

    if (rx.cs) begin
      state_d     = ST_IDLE;
      frame_err_d = (state_q == ST_DATA);
      if (cs_rise_s && dirty_s && AUTO_LATCH) begin
        copy_s   = 1'b1;
        update_d = 1'b1;
      end else begin
        copy_s = 1'b0;
      end
    end else if (rx.rx_rdy) begin
      case (state_q)
        ST_IDLE: begin
          case (opcode_s)
            OP_WRITE: begin
              if (!arg_s[3]) begin
                state_d = ST_DATA;
                addr_d  = arg_s[2:0];
              end else begin
                state_d     = ST_DISCARD;
                frame_err_d = 1'b1;
              end
            end
            OP_BURST: begin
              if (!arg_s[3]) begin
                state_d = ST_BURST;
                addr_d  = arg_s[2:0];
              end else begin
                state_d     = ST_DISCARD;
                frame_err_d = 1'b1;
              end
            end
            OP_LATCH: begin
              state_d = ST_DISCARD;
              if (arg_s == 4'h0) begin
                copy_s   = 1'b1;
                update_d = 1'b1;
              end else begin
                frame_err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              state_d = ST_DISCARD;
              if (arg_s == 4'h0) begin
                clr_s = 1'b1;
              end else begin
                frame_err_d = 1'b1;
              end
            end
            default: begin
              state_d     = ST_DISCARD;
              frame_err_d = 1'b1;
            end
          endcase
        end
        ST_DATA: begin
          wr_en_s = 1'b1;
          state_d = ST_DISCARD;
        end
        ST_BURST: begin
          wr_en_s = 1'b1;
          addr_d  = addr_q + 3'd1;
        end
        ST_DISCARD: begin
          frame_err_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer state, address counter, chip-select history and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 3'd0;
      cs_q        <= 1'b1;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      update_q    <= update_d;
      frame_err_q <= frame_err_d;
    end
  end

  rgbw_reg_bank u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (rx.rx_data),
    .clr     (clr_s),
    .copy    (copy_s),
    .active  (active_s),
    .dirty   (dirty_s)
  );

  assign red       = active_s[IDX_RED];
  assign green     = active_s[IDX_GREEN];
  assign blue      = active_s[IDX_BLUE];
  assign white     = active_s[IDX_WHITE];
  assign intensity = active_s[IDX_INTENSITY];
  assign mode      = active_s[IDX_MODE];
  assign update    = update_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rgbw_cmd_ctrl.sv
// Directed bench: one auto-latch and one manual-latch controller fed the same byte stream.
module tb_rgbw_cmd_ctrl;

  logic clk = 1'b0;
  logic reset;

  rgbw_cmd_ctrl_if rx_if ();

  logic [7:0] red_a, green_a, blue_a, white_a, intensity_a, mode_a;
  logic       update_a, frame_err_a;
  logic [7:0] red_b, green_b, blue_b, white_b, intensity_b, mode_b;
  logic       update_b, frame_err_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int upd_a = 0, upd_b = 0, err_a = 0, err_b = 0;
  int upd_a0, upd_b0, err_a0, err_b0;

  always #5 clk = ~clk;

  rgbw_cmd_ctrl #(.AUTO_LATCH(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_if.slave),
    .red(red_a), .green(green_a), .blue(blue_a), .white(white_a),
    .intensity(intensity_a), .mode(mode_a), .update(update_a), .frame_err(frame_err_a)
  );

  rgbw_cmd_ctrl #(.AUTO_LATCH(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_if.slave),
    .red(red_b), .green(green_b), .blue(blue_b), .white(white_b),
    .intensity(intensity_b), .mode(mode_b), .update(update_b), .frame_err(frame_err_b)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (update_a)    upd_a <= upd_a + 1;
    if (update_b)    upd_b <= upd_b + 1;
    if (frame_err_a) err_a <= err_a + 1;
    if (frame_err_b) err_b <= err_b + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_rdy  = 1'b1;
    rx_if.rx_data = b;
    @(negedge clk);
    rx_if.rx_rdy  = 1'b0;
  endtask

  task automatic cs_low();
    rx_if.cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_high();
    rx_if.cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    idle(1);
    upd_a0 = upd_a; upd_b0 = upd_b; err_a0 = err_a; err_b0 = err_b;
  endtask

  initial begin
    reset         = 1'b1;
    rx_if.cs      = 1'b1;
    rx_if.rx_rdy  = 1'b0;
    rx_if.rx_data = 8'h00;
    idle(3);
    check_val("rst_red",   {24'd0, red_a},   32'h00);
    check_val("rst_mode",  {24'd0, mode_b},  32'h00);
    check_val("rst_upd",   {31'd0, update_a}, 32'h0);
    check_val("rst_err",   {31'd0, frame_err_a}, 32'h0);
    reset = 1'b0;
    idle(2);

    // WRITE blue, auto-latch on chip-select release.
    cs_low();
    send_byte(8'h12);
    send_byte(8'h80);
    check_val("wr_blue_pre", {24'd0, blue_a}, 32'h00);
    cs_high();
    check_val("wr_blue_a",   {24'd0, blue_a}, 32'h80);
    check_val("wr_upd_a",    {31'd0, update_a}, 32'h1);
    check_val("wr_blue_b",   {24'd0, blue_b}, 32'h00);
    check_val("wr_upd_b",    {31'd0, update_b}, 32'h0);
    idle(1);
    check_val("wr_upd_a_end", {31'd0, update_a}, 32'h0);
    cs_low();
    send_byte(8'h30);
    check_val("latch_blue_b", {24'd0, blue_b}, 32'h80);
    check_val("latch_upd_b",  {31'd0, update_b}, 32'h1);
    cs_high();

    // Clear and latch both, then a wrapping burst.
    cs_low(); send_byte(8'h40); cs_high();
    check_val("clr_blue_a", {24'd0, blue_a}, 32'h00);
    cs_low(); send_byte(8'h30); cs_high();
    check_val("clr_blue_b", {24'd0, blue_b}, 32'h00);
    cs_low();
    send_byte(8'h25); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    cs_high();
    check_val("burst_mode",  {24'd0, mode_a},      32'h11);
    check_val("burst_red",   {24'd0, red_a},       32'h44);
    check_val("burst_green", {24'd0, green_a},     32'h00);
    check_val("burst_blue",  {24'd0, blue_a},      32'h00);
    check_val("burst_white", {24'd0, white_a},     32'h00);
    check_val("burst_int",   {24'd0, intensity_a}, 32'h00);
    check_val("burst_b_mode", {24'd0, mode_b},     32'h00);

    // LATCH timing on the manual controller.
    cs_low(); send_byte(8'h11); send_byte(8'h7F); cs_high();
    check_val("green_a_auto", {24'd0, green_a}, 32'h7F);
    cs_low();
    check_val("latch_green_pre", {24'd0, green_b}, 32'h00);
    send_byte(8'h30);
    check_val("latch_green_b", {24'd0, green_b}, 32'h7F);
    check_val("latch_red_b",   {24'd0, red_b},   32'h44);
    check_val("latch_upd_b1",  {31'd0, update_b}, 32'h1);
    check_val("latch_clean_a", {31'd0, update_a}, 32'h1);
    idle(1);
    check_val("latch_upd_b0",  {31'd0, update_b}, 32'h0);
    cs_high();

    // Protocol errors leave outputs alone.
    snap();
    cs_low(); send_byte(8'h55); cs_high();
    cs_low(); send_byte(8'h18); cs_high();
    cs_low(); send_byte(8'h11); cs_high();
    idle(1);
    check_val("err_cnt_a", err_a - err_a0, 32'd3);
    check_val("err_cnt_b", err_b - err_b0, 32'd3);
    check_val("err_no_upd", upd_a - upd_a0, 32'd0);
    check_val("err_red",   {24'd0, red_a},   32'h44);
    check_val("err_green", {24'd0, green_a}, 32'h7F);
    check_val("err_mode_b", {24'd0, mode_b}, 32'h11);

    // Extra byte after a WRITE.
    snap();
    cs_low(); send_byte(8'h10); send_byte(8'h01); send_byte(8'h02); cs_high();
    idle(1);
    check_val("extra_red", {24'd0, red_a}, 32'h01);
    check_val("extra_err", err_a - err_a0, 32'd1);

    // Byte coinciding with chip-select release is dropped silently.
    snap();
    cs_low(); send_byte(8'h24); send_byte(8'h09);
    rx_if.cs = 1'b1; rx_if.rx_rdy = 1'b1; rx_if.rx_data = 8'h77;
    @(negedge clk);
    rx_if.rx_rdy = 1'b0;
    idle(1);
    check_val("drop_int",  {24'd0, intensity_a}, 32'h09);
    check_val("drop_mode", {24'd0, mode_a},      32'h11);
    check_val("drop_err",  err_a - err_a0, 32'd0);

    // Reset in the middle of a burst, then finish the frame from IDLE.
    cs_low(); send_byte(8'h20); send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1;
    idle(1);
    check_val("mrst_red",   {24'd0, red_a},       32'h00);
    check_val("mrst_green", {24'd0, green_a},     32'h00);
    check_val("mrst_int",   {24'd0, intensity_a}, 32'h00);
    check_val("mrst_mode",  {24'd0, mode_a},      32'h00);
    check_val("mrst_red_b", {24'd0, red_b},       32'h00);
    reset = 1'b0;
    send_byte(8'h13); send_byte(8'h05);
    cs_high();
    check_val("post_white", {24'd0, white_a}, 32'h05);
    check_val("post_red",   {24'd0, red_a},   32'h00);
    check_val("post_upd",   {31'd0, update_a}, 32'h1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
